mux2_sel_arb: RTL and testbench

MUX2_SEL_ARB -- requirements
Module: mux2_sel_arb

---
 rtl/mux2_sel_arb.sv | 110 +++++++++++
 tb/tb_mux2_sel_arb.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux2_sel_arb.sv
// mux2_sel_arb: two-channel valid/ready arbiter feeding a one-entry output
// register. Ties alternate between channels; "so" tells the downstream
// mux_2_1 which channel the held payload came from.
module mux2_sel_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_valid,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_valid,
  output logic             i1_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             so
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] y_data_reg;
  logic             so_reg;
  logic             last_grant_reg;

  logic             ld;
  logic             pick_valid;
  logic             pick_idx;
  logic             accept;
  logic [WIDTH-1:0] pick_data;

  // Load enable: the output register is free when empty or being drained.
  assign ld = (state_reg == EMPTY) || y_ready;

  // Pick a channel: a lone valid wins outright, a tie goes to the channel
  // that was not granted last, so contention alternates fairly.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 1'b0;
    case ({i1_valid, i0_valid})
      2'b01: begin
        pick_valid = 1'b1;
        pick_idx   = 1'b0;
      end
      2'b10: begin
        pick_valid = 1'b1;
        pick_idx   = 1'b1;
      end
      2'b11: begin
        pick_valid = 1'b1;
        pick_idx   = ~last_grant_reg;
      end
      default: begin
        pick_valid = 1'b0;
        pick_idx   = 1'b0;
      end
    endcase
  end

  assign pick_data = pick_idx ? i1_data : i0_data;
  assign accept    = ld && pick_valid;

  // Readies are gated by rst_n so nothing looks accepted while in reset.
  assign i0_ready = rst_n && accept && !pick_idx;
  assign i1_ready = rst_n && accept &&  pick_idx;

  // EMPTY/FULL state machine with the output register, source index and
  // tie-break history; reset leaves last_grant=1 so ch0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      y_data_reg     <= '0;
      so_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg      <= FULL;
            y_data_reg     <= pick_data;
            so_reg         <= pick_idx;
            last_grant_reg <= pick_idx;
          end
        end
        FULL: begin
          if (accept) begin
            // Back-to-back reload on the same edge the consumer drains.
            y_data_reg     <= pick_data;
            so_reg         <= pick_idx;
            last_grant_reg <= pick_idx;
          end else if (y_ready) begin
            // Drained with nothing waiting; data and so keep their values.
            state_reg <= EMPTY;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign y_valid = (state_reg == FULL);
  assign y_data  = y_data_reg;
  assign so      = so_reg;

endmodule

// File: tb/tb_mux2_sel_arb.sv
// Directed bench for mux2_sel_arb: reset, single channel, tie alternation,
// backpressure, drain and stalled-request priority.
module tb_mux2_sel_arb;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] i0_data;
  logic             i0_valid;
  logic             i0_ready;
  logic [WIDTH-1:0] i1_data;
  logic             i1_valid;
  logic             i1_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_ready;
  logic             so;

  int n_cmp;
  int n_bad;

  mux2_sel_arb #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0_data  (i0_data),
    .i0_valid (i0_valid),
    .i0_ready (i0_ready),
    .i1_data  (i1_data),
    .i1_valid (i1_valid),
    .i1_ready (i1_ready),
    .y_data   (y_data),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .so       (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench is purely clock-driven, but never let it hang.
  initial begin
    #20000;
    $display("FAIL watchdog: sim time exceeded, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic s, input logic v);
    check_val({tag, ".y_data"},  32'(y_data),  32'(d));
    check_val({tag, ".so"},      32'(so),      32'(s));
    check_val({tag, ".y_valid"}, 32'(y_valid), 32'(v));
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    #1;
    check_val({tag, ".i0_ready"}, 32'(i0_ready), 32'(r0));
    check_val({tag, ".i1_ready"}, 32'(i1_ready), 32'(r1));
  endtask

  logic [7:0] tie_data [4];
  logic       tie_so   [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tie_data[0] = 8'h11; tie_data[1] = 8'h22; tie_data[2] = 8'h11; tie_data[3] = 8'h22;
    tie_so[0]   = 1'b0;  tie_so[1]   = 1'b1;  tie_so[2]   = 1'b0;  tie_so[3]   = 1'b1;

    // Reset with valids asserted: readies must stay low.
    rst_n = 1'b0;
    i0_data = 8'hA1; i0_valid = 1'b1;
    i1_data = 8'hB2; i1_valid = 1'b1;
    y_ready = 1'b1;
    step();
    step();
    check_out("reset", 8'h00, 1'b0, 1'b0);
    check_rdy("reset", 1'b0, 1'b0);
    i0_valid = 1'b0; i1_valid = 1'b0;
    rst_n = 1'b1;

    // Single channel 1.
    i1_valid = 1'b1; i1_data = 8'h5A;
    check_rdy("single", 1'b0, 1'b1);
    step();
    check_out("single", 8'h5A, 1'b1, 1'b1);

    // Async reset mid-cycle while FULL (hold with y_ready=0).
    i1_valid = 1'b0; y_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // Tie after reset: alternation starting with ch0, no bubbles.
    i0_valid = 1'b1; i0_data = 8'h11;
    i1_valid = 1'b1; i1_data = 8'h22;
    y_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_rdy($sformatf("tie%0d", k), !tie_so[k], tie_so[k]);
      step();
      check_out($sformatf("tie%0d", k), tie_data[k], tie_so[k], 1'b1);
    end

    // Load 0x33 from ch0 (last grant was ch1), then backpressure.
    i0_data = 8'h33; i1_data = 8'h44;
    step();
    check_out("load33", 8'h33, 1'b0, 1'b1);
    y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_rdy($sformatf("bp%0d", k), 1'b0, 1'b0);
      step();
      check_out($sformatf("bp%0d", k), 8'h33, 1'b0, 1'b1);
    end
    y_ready = 1'b1;
    check_rdy("bp_release", 1'b0, 1'b1);
    step();
    check_out("bp_release", 8'h44, 1'b1, 1'b1);

    // Drain: no valids, output empties but keeps data and so.
    i0_valid = 1'b0; i1_valid = 1'b0;
    check_rdy("drain", 1'b0, 1'b0);
    step();
    check_out("drain", 8'h44, 1'b1, 1'b0);

    // Stalled request: ch0 granted (last_grant=0), then stalls, then tie.
    i0_valid = 1'b1; i0_data = 8'h55;
    step();
    check_out("stall_load", 8'h55, 1'b0, 1'b1);
    y_ready = 1'b0; i0_data = 8'h66;
    check_rdy("stall_a", 1'b0, 1'b0);
    step();
    step();
    i1_valid = 1'b1; i1_data = 8'h77;
    check_rdy("stall_b", 1'b0, 1'b0);
    step();
    check_out("stall_hold", 8'h55, 1'b0, 1'b1);
    y_ready = 1'b1;
    check_rdy("stall_rel", 1'b0, 1'b1);
    step();
    check_out("stall_rel", 8'h77, 1'b1, 1'b1);
    step();
    check_out("stall_next", 8'h66, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
